xnor_resp_checker: RTL and testbench
====================================

// Module: xnor_resp_checker
// PURPOSE
//  Synthesizable response checker: the observing end of the xnorgate stimulus/monitor flow.
//  Samples each applied vector {a,b} with the gate's output y under a valid/ready handshake.
//  Compares y against the golden result ~(a^b), counts vectors and mismatches, and latches the first failure.
//  Flags done/pass after NUM_VEC vectors. Sits beside any xnorgate instance on the bench or FPGA self-test.
// PARAMETERS
//  WIDTH      1  bit width of a, b, y (bitwise XNOR)
//  NUM_VEC    4  vectors per run (>=1)
//  CNT_W      8  width of vec_cnt/err_cnt/index fields; NUM_VEC <= 2**CNT_W-1
//  FIFO_DEPTH 4  failure-log entries (power of 2, used only with FAIL_FIFO_EN)
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            asynchronous reset, active-high
//  start       in   1            begin run (sampled in IDLE/DONE only)
//  vld         in   1            a/b/y valid this cycle
//  a,b,y       in   WIDTH        operands and gate-under-test output
//  rdy         out  1            checker accepts a vector (state CHECK)
//  busy        out  1            state CHECK
//  done        out  1            run complete (state DONE)
//  pass        out  1            done && err_cnt==0
//  vec_cnt     out  CNT_W        vectors accepted this run
//  err_cnt     out  CNT_W        mismatching vectors, saturates at all-ones
//  first_err_idx out CNT_W       index (0-based) of first mismatch
//  first_err_a/_b/_y out WIDTH   operands/output of first mismatch
//  fail_pop    in   1            pop one failure-log entry
//  fail_empty  out  1            failure log empty
//  fail_ovf    out  1            sticky: failure dropped because log full
//  fail_dout   out  CNT_W+3*WIDTH {idx,a,b,y} at log head (show-ahead)
// BEHAVIOUR
//  - Reset (async, any time): state IDLE; all outputs/counters/first_err_* 0; log emptied, fail_empty=1, fail_ovf=0.
//  - FSM: IDLE --start--> CHECK; CHECK --accept of vector NUM_VEC--> DONE; DONE --start--> CHECK.
//  - Entering CHECK (edge sampling start): vec_cnt, err_cnt, first_err_*, log, fail_ovf cleared.
//  - start while in CHECK ignored. vld outside CHECK ignored (rdy=0).
//  - Accept = vld && rdy. On accepting edge: vec_cnt+1. If y != ~(a^b) (any bit): err_cnt+1 (saturating).
//    If err_cnt was 0, capture first_err_idx=vec_cnt (old value), first_err_a/b/y.
//  - Latency: counters/first_err_* registered; visible the cycle after the accepting edge.
//  - The accepting edge for vector NUM_VEC also moves to DONE. done/pass valid that next cycle; rdy drops.
//  - DONE holds all results until start or rst. rdy high every CHECK cycle; back-to-back accepts allowed.
//  - vld may drop any cycle; no vector is lost or double-counted.
// CONFIGURATION
//  FAIL_FIFO_EN defined: each mismatch pushes {idx,a,b,y} into a FIFO_DEPTH log.
//    Push while full drops the entry and sets fail_ovf (sticky until start/rst).
//    fail_pop with !fail_empty advances head; pop while empty ignored.
//    Simultaneous push+pop when full: both take effect, no overflow.
//    Log is readable in CHECK and DONE.
//  FAIL_FIFO_EN undefined: no storage; fail_empty=1, fail_ovf=0, fail_dout=0, fail_pop ignored.
// TESTING  (WIDTH=1, NUM_VEC=4)
//  1 rst=1 mid-cycle -> immediately rdy=0, done=0, vec_cnt=0, err_cnt=0, fail_empty=1.
//  2 start; vectors (a,b,y)=(0,0,1),(0,1,0),(1,0,0),(1,1,1) back-to-back -> done=1, pass=1, vec_cnt=4, err_cnt=0.
//  3 as 2 but vector 1 = (0,1,1), vector 3 = (1,1,0)
//    -> err_cnt=2, first_err_idx=1, first_err_a/b/y=0/1/1, pass=0.
//  4 vld pulsed in IDLE and in DONE, and gaps of 3 idle cycles between vectors in CHECK
//    -> only CHECK vectors counted, vec_cnt=4.
//  5 rst after 2 vectors accepted -> all cleared, IDLE; new start + 4 good vectors -> pass=1.
//  6 FAIL_FIFO_EN, FIFO_DEPTH=2, all 4 vectors wrong
//    -> log holds idx 0,1; fail_ovf=1; two pops return idx 0 then 1; fail_empty=1.

Source files
------------

// File: rtl/xnor_resp_checker_if.sv
// Vector handshake bundle between the stimulus side and the checker.
// Stimulus drives vld/a/b/y; the checker answers with rdy.
interface xnor_resp_checker_if #(
   parameter int WIDTH = 1
);
   logic             vld;
   logic             rdy;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] y;

   modport master (output vld, output a, output b, output y, input rdy);
   modport slave  (input vld, input a, input b, input y, output rdy);
endinterface

// File: rtl/xnor_resp_checker.sv
// Response checker for an XNOR gate: counts vectors and mismatches, latches first failure.
// Optional failure log enabled by defining FAIL_FIFO_EN.
module xnor_resp_checker #(
   parameter int WIDTH      = 1,
   parameter int NUM_VEC    = 4,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   xnor_resp_checker_if.slave       bus,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [CNT_W-1:0]         vec_cnt,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [CNT_W-1:0]         first_err_idx,
   output logic [WIDTH-1:0]         first_err_a,
   output logic [WIDTH-1:0]         first_err_b,
   output logic [WIDTH-1:0]         first_err_y,
   input  logic                     fail_pop,
   output logic                     fail_empty,
   output logic                     fail_ovf,
   output logic [CNT_W+3*WIDTH-1:0] fail_dout
);

   localparam int DW = CNT_W + 3 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
   logic [WIDTH-1:0] fe_a_q, fe_a_d;
   logic [WIDTH-1:0] fe_b_q, fe_b_d;
   logic [WIDTH-1:0] fe_y_q, fe_y_d;

   logic accept;
   logic mismatch;
   logic run_start;

   // rdy_q is high exactly in CHECK, so it also qualifies the handshake
   assign accept    = bus.vld && rdy_q;
   assign mismatch  = |(bus.y ^ ~(bus.a ^ bus.b));
   assign run_start = (state_q != S_CHECK) && start;

   // Next-state, counter and first-failure capture logic
   always_comb begin
      state_d   = state_q;
      vec_cnt_d = vec_cnt_q;
      err_cnt_d = err_cnt_q;
      fe_idx_d  = fe_idx_q;
      fe_a_d    = fe_a_q;
      fe_b_d    = fe_b_q;
      fe_y_d    = fe_y_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_CHECK;
               vec_cnt_d = '0;
               err_cnt_d = '0;
               fe_idx_d  = '0;
               fe_a_d    = '0;
               fe_b_d    = '0;
               fe_y_d    = '0;
            end
         end
         S_CHECK: begin
            if (accept) begin
               vec_cnt_d = vec_cnt_q + 1'b1;
               if (mismatch) begin
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                  if (err_cnt_q == '0) begin
                     fe_idx_d = vec_cnt_q;
                     fe_a_d   = bus.a;
                     fe_b_d   = bus.b;
                     fe_y_d   = bus.y;
                  end
               end
               if (vec_cnt_q == CNT_W'(NUM_VEC - 1)) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      rdy_d  = (state_d == S_CHECK);
      busy_d = (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
      pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
   end

   // Control state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         vec_cnt_q <= '0;
         err_cnt_q <= '0;
         fe_idx_q  <= '0;
         fe_a_q    <= '0;
         fe_b_q    <= '0;
         fe_y_q    <= '0;
      end else begin
         state_q   <= state_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         vec_cnt_q <= vec_cnt_d;
         err_cnt_q <= err_cnt_d;
         fe_idx_q  <= fe_idx_d;
         fe_a_q    <= fe_a_d;
         fe_b_q    <= fe_b_d;
         fe_y_q    <= fe_y_d;
      end
   end

   assign bus.rdy       = rdy_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign vec_cnt       = vec_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_idx = fe_idx_q;
   assign first_err_a   = fe_a_q;
   assign first_err_b   = fe_b_q;
   assign first_err_y   = fe_y_q;

`ifdef FAIL_FIFO_EN
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic [DW-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, full, do_push;

   assign push    = accept && mismatch;
   assign pop     = fail_pop && (cnt_q != '0);
   assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
   // a pop frees the head slot in the same cycle, so a full log still takes the push
   assign do_push = push && (!full || pop);

   // Failure log pointers, occupancy and sticky overflow
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (run_start) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (push && !do_push) ovf_d = 1'b1;
         if (do_push) begin
            mem_d[wr_q] = {vec_cnt_q, bus.a, bus.b, bus.y};
            wr_d = (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
         end
         if (pop) begin
            rd_d = (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
         end
         cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
      end
   end

   // Failure log storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign fail_empty = (cnt_q == '0);
   assign fail_ovf   = ovf_q;
   assign fail_dout  = mem_q[rd_q];
`else
   logic        unused_fail_pop;
   logic        unused_run_start;
   logic [31:0] unused_depth;

   assign unused_fail_pop  = fail_pop;
   assign unused_run_start = run_start;
   assign unused_depth     = FIFO_DEPTH;
   assign fail_empty       = 1'b1;
   assign fail_ovf         = 1'b0;
   assign fail_dout        = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_xnor_resp_checker.sv
// Directed self-checking bench for xnor_resp_checker (WIDTH=1, NUM_VEC=4).
// Build with FAIL_FIFO_EN defined to also exercise the failure log (depth 2).
module tb_xnor_resp_checker;

   localparam int WIDTH   = 1;
   localparam int NUM_VEC = 4;
   localparam int CNT_W   = 8;
   localparam int DEPTH   = 2;
   localparam int DW      = CNT_W + 3 * WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy, done, pass;
   logic [CNT_W-1:0] vec_cnt, err_cnt, first_err_idx;
   logic [WIDTH-1:0] first_err_a, first_err_b, first_err_y;
   logic             fail_pop, fail_empty, fail_ovf;
   logic [DW-1:0]    fail_dout;

   int checks = 0;
   int errors = 0;

   xnor_resp_checker_if #(.WIDTH(WIDTH)) bus ();

   xnor_resp_checker #(
      .WIDTH(WIDTH), .NUM_VEC(NUM_VEC), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .busy(busy), .done(done), .pass(pass),
      .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
      .first_err_a(first_err_a), .first_err_b(first_err_b),
      .first_err_y(first_err_y),
      .fail_pop(fail_pop), .fail_empty(fail_empty), .fail_ovf(fail_ovf),
      .fail_dout(fail_dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic a, input logic b, input logic y);
      bus.vld = 1'b1;
      bus.a   = a;
      bus.b   = b;
      bus.y   = y;
      tick();
      bus.vld = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      fail_pop = 1'b0;
      bus.vld  = 1'b0;
      bus.a    = 1'b0;
      bus.b    = 1'b0;
      bus.y    = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      chk("rst_rdy", bus.rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_vec", vec_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_empty", fail_empty, 1);
      chk("rst_ovf", fail_ovf, 0);
      chk("rst_dout", fail_dout, 0);

      // test 1: async reset mid-cycle
      pulse_start();
      chk("t1_rdy", bus.rdy, 1);
      chk("t1_busy", busy, 1);
      send(1'b0, 1'b0, 1'b1);
      chk("t1_vec1", vec_cnt, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("t1_arst_rdy", bus.rdy, 0);
      chk("t1_arst_done", done, 0);
      chk("t1_arst_vec", vec_cnt, 0);
      chk("t1_arst_err", err_cnt, 0);
      chk("t1_arst_empty", fail_empty, 1);
      tick();
      rst = 1'b0;

      // test 2: all-good run back-to-back
      pulse_start();
      send(1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b0, 1'b0);
      chk("t2_not_done", done, 0);
      send(1'b1, 1'b1, 1'b1);
      chk("t2_done", done, 1);
      chk("t2_pass", pass, 1);
      chk("t2_vec", vec_cnt, 4);
      chk("t2_err", err_cnt, 0);
      chk("t2_rdy", bus.rdy, 0);
      chk("t2_busy", busy, 0);

      // test 3: errors on vectors 1 and 3
      pulse_start();
      chk("t3_vec0", vec_cnt, 0);
      send(1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b1, 1'b1);
      chk("t3_err1", err_cnt, 1);
      send(1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      chk("t3_done", done, 1);
      chk("t3_pass", pass, 0);
      chk("t3_err", err_cnt, 2);
      chk("t3_idx", first_err_idx, 1);
      chk("t3_fa", first_err_a, 0);
      chk("t3_fb", first_err_b, 1);
      chk("t3_fy", first_err_y, 1);

      // test 4: vld in DONE ignored, gaps in CHECK, start ignored in CHECK
      send(1'b1, 1'b1, 1'b0);
      chk("t4_done_vld_vec", vec_cnt, 4);
      chk("t4_done_vld_err", err_cnt, 2);
      pulse_start();
      chk("t4_clr_err", err_cnt, 0);
      chk("t4_clr_idx", first_err_idx, 0);
      chk("t4_clr_fy", first_err_y, 0);
      send(1'b0, 1'b0, 1'b1);
      repeat (3) tick();
      send(1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      pulse_start();
      chk("t4_start_ign_vec", vec_cnt, 2);
      chk("t4_start_ign_busy", busy, 1);
      send(1'b1, 1'b0, 1'b0);
      repeat (3) tick();
      chk("t4_gap_vec", vec_cnt, 3);
      send(1'b1, 1'b1, 1'b1);
      chk("t4_done", done, 1);
      chk("t4_vec", vec_cnt, 4);
      chk("t4_pass", pass, 1);
      send(1'b0, 1'b0, 1'b1);
      chk("t4_done_vld2", vec_cnt, 4);

      // test 5: reset after two vectors, vld in IDLE, fresh run
      pulse_start();
      send(1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b1, 1'b0);
      chk("t5_vec2", vec_cnt, 2);
      #3;
      rst = 1'b1;
      #1;
      chk("t5_arst_vec", vec_cnt, 0);
      chk("t5_arst_busy", busy, 0);
      tick();
      rst = 1'b0;
      send(1'b1, 1'b1, 1'b0);
      chk("t5_idle_vec", vec_cnt, 0);
      chk("t5_idle_err", err_cnt, 0);
      chk("t5_idle_done", done, 0);
      pulse_start();
      send(1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b1);
      chk("t5_done", done, 1);
      chk("t5_pass", pass, 1);
      chk("t5_vec", vec_cnt, 4);

      // test 6: all four vectors wrong
      pulse_start();
      send(1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b1);
      send(1'b1, 1'b0, 1'b1);
      send(1'b1, 1'b1, 1'b0);
      chk("t6_err", err_cnt, 4);
      chk("t6_idx", first_err_idx, 0);
      chk("t6_pass", pass, 0);
`ifdef FAIL_FIFO_EN
      chk("t6_ovf", fail_ovf, 1);
      chk("t6_empty0", fail_empty, 0);
      chk("t6_head0", fail_dout, 11'h000);
      fail_pop = 1'b1;
      tick();
      fail_pop = 1'b0;
      chk("t6_head1", fail_dout, 11'h00B);
      chk("t6_empty1", fail_empty, 0);
      fail_pop = 1'b1;
      tick();
      chk("t6_empty2", fail_empty, 1);
      tick();
      fail_pop = 1'b0;
      chk("t6_empty3", fail_empty, 1);
      chk("t6_ovf_sticky", fail_ovf, 1);
      pulse_start();
      chk("t6_ovf_clr", fail_ovf, 0);
`else
      chk("t6_nolog_empty", fail_empty, 1);
      chk("t6_nolog_ovf", fail_ovf, 0);
      chk("t6_nolog_dout", fail_dout, 0);
      fail_pop = 1'b1;
      tick();
      fail_pop = 1'b0;
      chk("t6_nolog_pop", fail_empty, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
